// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding and the legal op range.
package alu_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int ALU_OP_MAX = 9;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } alu_op_e;

    function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
        return op > ALU_OP_W'(ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around and
// moves the pointer one past the winner when the grant is actually taken.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    always_comb begin
        o_grant = '0;
        gidx    = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                gidx         = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance) begin
            ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: issue register
// drives the ALU, response register returns result + owner ID.
// Optional illegal-op check enabled by defining ALU_ARB_OPCHK_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int DATA_W  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_op_a,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_op_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0] i_req_alu_op,
    output logic [DATA_W-1:0]           o_alu_op_a,
    output logic [DATA_W-1:0]           o_alu_op_b,
    output logic [ALU_OP_W-1:0]         o_alu_op,
    input  logic [DATA_W-1:0]           i_alu_data,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [DATA_W-1:0]           o_rsp_data,
    output logic [ID_W-1:0]             o_rsp_id,
    output logic                        o_rsp_err
);

    logic                iss_vld_q, iss_vld_d;
    logic [DATA_W-1:0]   iss_a_q, iss_a_d;
    logic [DATA_W-1:0]   iss_b_q, iss_b_d;
    logic [ALU_OP_W-1:0] iss_op_q, iss_op_d;
    logic [ID_W-1:0]     iss_id_q, iss_id_d;

    logic                rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic                rsp_en, iss_free, xfer;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     rr_ptr;
    logic                unused_rr_ptr;

    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [ALU_OP_W-1:0] sel_op;
    logic [ID_W-1:0]     sel_id;
    logic [DATA_W-1:0]   res_data;

    assign rsp_en   = iss_vld_q & (~rsp_vld_q | i_rsp_ready);
    assign iss_free = ~iss_vld_q | rsp_en;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req_valid),
        .i_advance (xfer),
        .o_grant   (grant),
        .o_ptr     (rr_ptr)
    );

    // The pointer lives inside the arbiter; the top only needs the grant.
    assign unused_rr_ptr = ^rr_ptr;

    assign o_req_ready = grant & {NUM_REQ{iss_free}};
    assign xfer        = |(i_req_valid & o_req_ready);

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        sel_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_a  = i_req_op_a[k*DATA_W +: DATA_W];
                sel_b  = i_req_op_b[k*DATA_W +: DATA_W];
                sel_op = i_req_alu_op[k*ALU_OP_W +: ALU_OP_W];
                sel_id = ID_W'(k);
            end
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    logic rsp_err_q, rsp_err_d;
    logic iss_illegal;

    assign iss_illegal = op_illegal(iss_op_q);
    assign res_data    = iss_illegal ? '0 : i_alu_data;

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (rsp_en) rsp_err_d = iss_illegal;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rsp_err_q <= 1'b0;
        else          rsp_err_q <= rsp_err_d;
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign res_data  = i_alu_data;
    assign o_rsp_err = 1'b0;
`endif

    always_comb begin
        iss_vld_d = iss_vld_q;
        iss_a_d   = iss_a_q;
        iss_b_d   = iss_b_q;
        iss_op_d  = iss_op_q;
        iss_id_d  = iss_id_q;
        if (xfer) begin
            iss_vld_d = 1'b1;
            iss_a_d   = sel_a;
            iss_b_d   = sel_b;
            iss_op_d  = sel_op;
            iss_id_d  = sel_id;
        end else if (rsp_en) begin
            iss_vld_d = 1'b0;
        end
    end

    // Pop and push may coincide; the response stage refills from issue.
    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (rsp_en) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = res_data;
            rsp_id_d   = iss_id_q;
        end else if (i_rsp_ready) begin
            rsp_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            iss_vld_q  <= 1'b0;
            iss_a_q    <= '0;
            iss_b_q    <= '0;
            iss_op_q   <= '0;
            iss_id_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            iss_a_q    <= iss_a_d;
            iss_b_q    <= iss_b_d;
            iss_op_q   <= iss_op_d;
            iss_id_q   <= iss_id_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign o_alu_op_a  = iss_a_q;
    assign o_alu_op_b  = iss_b_q;
    assign o_alu_op    = iss_op_q;
    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model,
// directed steps from the test plan plus a randomized traffic phase.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0, req_b = '0;
    logic [N*4-1:0]  req_op = '0;
    logic [31:0]     alu_a, alu_b, alu_data;
    logic [3:0]      alu_op;
    logic            rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0]     rsp_data;
    logic [IW-1:0]   rsp_id;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op_a   (req_a),
        .i_req_op_b   (req_b),
        .i_req_alu_op (req_op),
        .o_alu_op_a   (alu_a),
        .o_alu_op_b   (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_data   (alu_data),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .o_rsp_err    (rsp_err)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_data = alu_f(alu_a, alu_b, alu_op);

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; } req_t;
    typedef struct { logic [31:0] data; int id; logic err; bit in_rsp; } exp_t;

    req_t rq[N][$];
    exp_t mq[$];
    int   ptr = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [N-1:0] last_ready;

    int          obs_gnt[$];
    int          obs_id[$];
    int          obs_cyc[$];
    logic [31:0] obs_data[$];
    logic        obs_err[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        req_t r;
        r.a = a; r.b = b; r.op = op;
        rq[k].push_back(r);
    endtask

    task automatic clear_obs();
        obs_gnt.delete(); obs_id.delete(); obs_cyc.delete();
        obs_data.delete(); obs_err.delete();
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = rq[k].size() > 0;
            if (rq[k].size() > 0) begin
                req_a[k*32 +: 32] = rq[k][0].a;
                req_b[k*32 +: 32] = rq[k][0].b;
                req_op[k*4 +: 4]  = rq[k][0].op;
            end
        end
    endtask

    // One clock: check against the model at negedge, advance the model at posedge.
    task automatic tick();
        int   g;
        bit   free, exp_v;
        logic [N-1:0] exp_ready;
        exp_t e;
        req_t r;
        drive();
        @(negedge clk);
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
        end
        free      = !(mq.size() == 2 && !rsp_ready);
        exp_ready = (g >= 0 && free) ? N'(1 << g) : '0;
        exp_v     = mq.size() > 0 && mq[0].in_rsp;
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_data", rsp_data, mq[0].data);
            chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
            chk("rsp_err", 32'(rsp_err), 32'(mq[0].err));
        end
        for (int k = 0; k < N; k++) if (req_ready[k]) obs_gnt.push_back(k);
        if (rsp_valid && rsp_ready) begin
            obs_data.push_back(rsp_data);
            obs_id.push_back(int'(rsp_id));
            obs_err.push_back(rsp_err);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (exp_v && rsp_ready) void'(mq.pop_front());
        if (mq.size() > 0 && !mq[0].in_rsp) begin
            e = mq[0]; e.in_rsp = 1'b1; mq[0] = e;
        end
        if (g >= 0 && free) begin
            r = rq[g].pop_front();
`ifdef ALU_ARB_OPCHK_EN
            e.err = (r.op >= 4'd10);
`else
            e.err = 1'b0;
`endif
            e.data   = alu_f(r.a, r.b, r.op);
            e.id     = g;
            e.in_rsp = 1'b0;
            mq.push_back(e);
            ptr = (g + 1) % N;
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || pending()) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;

        // Single ADD: ready same cycle, response after the next edge
        push(0, 32'd5, 32'd7, 4'd0);
        tick();
        chk("add_ready", 32'(last_ready), 32'd1);
        tick();
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_data", rsp_data, 32'd12);
        chk("add_rsp_id", 32'(rsp_id), 32'd0);
        drain();

        // Filler from req1 so the pointer is back at 0
        push(1, 32'd1, 32'd4, 4'd2);
        drain();

        // Contention
        clear_obs();
        push(0, 32'd1, 32'd1, 4'd0);
        push(0, 32'hF0F0, 32'h0FF0, 4'd5);
        push(1, 32'd9, 32'd3, 4'd1);
        push(1, 32'hFF, 32'h0F, 4'd9);
        drain();
        chk("cont_ngrants", 32'(obs_gnt.size()), 32'd4);
        chk("cont_nrsp", 32'(obs_id.size()), 32'd4);
        if (obs_gnt.size() == 4 && obs_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_grant_order", 32'(obs_gnt[i]), 32'(i % 2));
                chk("cont_rsp_id_order", 32'(obs_id[i]), 32'(i % 2));
            end
            chk("cont_rsp_consecutive", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);
        end

        // Backpressure
        rsp_ready = 1'b0;
        push(0, 32'd3, 32'd5, 4'd1);
        push(0, 32'h8000_0000, 32'd4, 4'd7);
        tick();
        tick();
        push(1, 32'd2, 32'd2, 4'd0);
        repeat (3) tick();
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_hold_data", rsp_data, 32'hFFFF_FFFE);
        clear_obs();
        rsp_ready = 1'b1;
        drain();
        chk("bp_nrsp", 32'(obs_data.size()), 32'd3);
        if (obs_data.size() >= 2) begin
            chk("bp_first", obs_data[0], 32'hFFFF_FFFE);
            chk("bp_second", obs_data[1], 32'hF800_0000);
        end

        // Throughput: 8 back-to-back from req1
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            if (i == 2)      push(1, 32'd1, 32'hFFFF_FFFF, 4'd4);
            else if (i == 5) push(1, 32'd1, 32'hFFFF_FFFF, 4'd3);
            else             push(1, $urandom, $urandom, 4'($urandom_range(0, 9)));
        end
        drain();
        chk("thru_nrsp", 32'(obs_data.size()), 32'd8);
        if (obs_data.size() == 8) begin
            chk("thru_span", 32'(obs_cyc[7] - obs_cyc[0]), 32'd7);
            chk("thru_sltu", obs_data[2], 32'd1);
            chk("thru_slt", obs_data[5], 32'd0);
        end

        // Illegal op
        clear_obs();
        push(0, 32'h1234, 32'h5678, 4'd12);
        drain();
        chk("ill_nrsp", 32'(obs_data.size()), 32'd1);
        if (obs_data.size() == 1) begin
            chk("ill_data", obs_data[0], 32'd0);
`ifdef ALU_ARB_OPCHK_EN
            chk("ill_err", 32'(obs_err[0]), 32'd1);
`else
            chk("ill_err", 32'(obs_err[0]), 32'd0);
`endif
        end

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() == 0 && $urandom_range(0, 2) == 0)
                    push(k, $urandom, 32'($urandom_range(0, 40)), 4'($urandom_range(0, 15)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rsp_ready = 1'b1;
        drain();

        // Reset mid-flight with both stages full and the pointer at 1
        rsp_ready = 1'b0;
        push(0, 32'd10, 32'd20, 4'd0);
        push(0, 32'd30, 32'd40, 4'd8);
        repeat (3) tick();
        chk("mid_full_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        mq.delete();
        ptr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        push(0, 32'd7, 32'd1, 4'd1);
        push(1, 32'd7, 32'd2, 4'd1);
        tick();
        chk("mid_ptr_reset_grant", 32'(last_ready), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
